bcd_display_scanner: RTL and testbench

- Reads the 16-bit packed 4-digit BCD count produced by the millisecond counter (format hhh.t: digit3 = hundreds … digit0 = tenths).
- Time-multiplexes that count onto a 4-digit common-anode seven-segment display.
- Provides a hold (lap-freeze) capture register and a fixed decimal point.
- Flags non-BCD digits.
- Sits between the stopwatch datapath and board display pins.

---
 rtl/bcd_display_pkg.sv | 23 ++
 rtl/bcd_display_seg7_decode.sv | 29 ++
 rtl/bcd_display_scanner.sv | 92 +++++++++
 tb/tb_bcd_display_scanner.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_pkg.sv
// Shared constants for the BCD display scanner: active-low seven-segment
// patterns ({g,f,e,d,c,b,a}) and the prescaler width helper.
package bcd_display_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Width of a counter that must hold 0..div-1; never narrower than 1 bit.
    function automatic int presc_width(input int div);
        return ($clog2(div) < 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/bcd_display_seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment decoder; non-decimal
// nibbles (A-F) show a dash so corrupted digits are visible on the board.
module seg7_decode
    import bcd_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: default before the case so every path assigns seg; a missing
        // branch would otherwise infer a latch.
        seg = SEG_DASH;
        unique case (nibble)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexes a captured 4-digit BCD value onto a common-anode display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros above DP_DIGIT.
module bcd_display_scanner
    import bcd_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DP_DIGIT    = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] SCin,
    input  logic        Hold,
    output logic [3:0]  An,
    output logic [6:0]  Seg,
    output logic        DP,
    output logic        Invalid
);

    localparam int               PRESC_W   = presc_width(REFRESH_DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [1:0]       DP_IDX    = 2'(DP_DIGIT);

    logic [15:0]        cap_reg;
    logic [PRESC_W-1:0] presc;
    logic [1:0]         idx;

    logic [3:0] cur_nibble;
    logic [6:0] dec_seg;
    logic [3:0] an_next;
    logic [6:0] seg_next;
    logic       dp_next;
    logic       invalid_next;
    logic       blank_digit;

    seg7_decode u_decode (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        cur_nibble   = cap_reg[{idx, 2'b00} +: 4];
        an_next      = ~(4'b0001 << idx);
        dp_next      = (idx != DP_IDX);
        invalid_next = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cap_reg[4*i +: 4] > 4'd9) invalid_next = 1'b1;
        end
`ifdef LEADING_ZERO_BLANK_EN
        begin
            // zero_above[i]: digit i and every higher digit are zero.
            logic [3:0] zero_above;
            zero_above[3] = (cap_reg[15:12] == 4'd0);
            zero_above[2] = zero_above[3] && (cap_reg[11:8] == 4'd0);
            zero_above[1] = zero_above[2] && (cap_reg[7:4]  == 4'd0);
            zero_above[0] = zero_above[1] && (cap_reg[3:0]  == 4'd0);
            blank_digit   = (idx > DP_IDX) && zero_above[idx];
        end
`else
        blank_digit = 1'b0;
`endif
        seg_next = blank_digit ? SEG_BLANK : dec_seg;
    end

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge
        // values; output registers must see the old idx and cap_reg.
        if (Reset) begin
            cap_reg <= '0;
            presc   <= '0;
            idx     <= 2'd0;
            An      <= 4'b1111;
            Seg     <= SEG_BLANK;
            DP      <= 1'b1;
            Invalid <= 1'b0;
        end else begin
            if (!Hold) cap_reg <= SCin;

            if (presc == PRESC_MAX) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + 1'b1;
            end

            An      <= an_next;
            Seg     <= seg_next;
            DP      <= dp_next;
            Invalid <= invalid_next;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench: a per-cycle model (digit = elapsed cycles / divider)
// checks two scanners (REFRESH_DIV=4 and 1), plus hand-computed literals.
module tb_bcd_display_scanner;

    localparam int DP_DIG = 1;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] SCin;
    logic        Hold;
    logic [3:0]  An4, An1;
    logic [6:0]  Seg4, Seg1;
    logic        DP4, DP1, Inv4, Inv1;

    int tests  = 0;
    int failed = 0;

    always #5 Clk = ~Clk;

    bcd_display_scanner #(.REFRESH_DIV(4), .DP_DIGIT(DP_DIG)) dut4 (
        .Clk(Clk), .Reset(Reset), .SCin(SCin), .Hold(Hold),
        .An(An4), .Seg(Seg4), .DP(DP4), .Invalid(Inv4)
    );

    bcd_display_scanner #(.REFRESH_DIV(1), .DP_DIGIT(DP_DIG)) dut1 (
        .Clk(Clk), .Reset(Reset), .SCin(SCin), .Hold(Hold),
        .An(An1), .Seg(Seg1), .DP(DP1), .Invalid(Inv1)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Active-high standard patterns {g..a}; the display wants the inverse.
    function automatic logic [6:0] digit_pattern(input logic [3:0] nib);
        logic [6:0] hi [10];
        hi = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (nib > 4'd9) return 7'h3F;
        return ~hi[nib];
    endfunction

    // Outputs after the n-th non-reset edge, given the value captured before it.
    function automatic logic [12:0] model_out(input int div, input int n, input logic [15:0] cap);
        int         d;
        logic [3:0] an;
        logic [6:0] s;
        logic       inv;
        d   = ((n - 1) / div) % 4;
        an  = 4'b1111;
        an[d] = 1'b0;
        s   = digit_pattern(cap[4*d +: 4]);
        inv = 1'b0;
        for (int i = 0; i < 4; i++) if (cap[4*i +: 4] > 4'd9) inv = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > DP_DIG && (cap >> (4*d)) == 16'd0) s = 7'h7F;
`endif
        return {an, s, (d == DP_DIG) ? 1'b0 : 1'b1, inv};
    endfunction

    logic [15:0] m_cap   = '0;
    int          m_n     = 0;
    bit          m_valid = 0;

    always @(posedge Clk) begin
        logic [12:0] e4, e1;
        bit          do_chk;
        if (Reset === 1'b1) begin
            m_valid = 1;
            m_n     = 0;
            m_cap   = '0;
            e4      = {4'hF, 7'h7F, 1'b1, 1'b0};
            e1      = e4;
        end else begin
            m_n++;
            e4 = model_out(4, m_n, m_cap);
            e1 = model_out(1, m_n, m_cap);
            if (!Hold) m_cap = SCin;
        end
        do_chk = m_valid;
        #1;
        if (do_chk) begin
            check("cyc_an4",  {12'b0, An4},  {12'b0, e4[12:9]});
            check("cyc_seg4", {9'b0, Seg4},  {9'b0, e4[8:2]});
            check("cyc_dp4",  {15'b0, DP4},  {15'b0, e4[1]});
            check("cyc_inv4", {15'b0, Inv4}, {15'b0, e4[0]});
            check("cyc_an1",  {12'b0, An1},  {12'b0, e1[12:9]});
            check("cyc_seg1", {9'b0, Seg1},  {9'b0, e1[8:2]});
            check("cyc_dp1",  {15'b0, DP1},  {15'b0, e1[1]});
            check("cyc_inv1", {15'b0, Inv1}, {15'b0, e1[0]});
        end
    end

    task automatic step(input int k);
        repeat (k) @(negedge Clk);
    endtask

    task automatic wait_an(input string name, input logic [3:0] want);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (An4 === want) begin
                ok = 1;
                break;
            end
        end
        check(name, {15'b0, ok}, 16'd1);
    endtask

    initial begin
        logic [3:0] an1_seq [5];
        an1_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        Reset = 1'b1;
        SCin  = 16'h1234;
        Hold  = 1'b0;
        step(3);
        check("reset_an",  {12'b0, An4},  16'h000F);
        check("reset_seg", {9'b0, Seg4},  16'h007F);
        check("reset_dp",  {15'b0, DP4},  16'd1);
        check("reset_inv", {15'b0, Inv4}, 16'd0);

        // 1: scan order and digit contents of 1234
        Reset = 1'b0;
        step(1);
        check("first_an", {12'b0, An4}, 16'b1110);
        step(1);
        check("d0_seg_4", {9'b0, Seg4}, 16'h0019);
        step(3);
        check("d1_an",    {12'b0, An4}, 16'b1101);
        check("d1_seg_3", {9'b0, Seg4}, 16'h0030);
        check("d1_dp",    {15'b0, DP4}, 16'd0);
        step(24);

        // 2: hold freezes 0999 while SCin moves to 1000
        SCin = 16'h0999;
        step(20);
        Hold = 1'b1;
        SCin = 16'h1000;
        step(10);
        wait_an("wait_hold_d2", 4'b1011);
        check("hold_d2_seg_9", {9'b0, Seg4}, 16'h0010);
        step(10);
        Hold = 1'b0;
        step(4);
        wait_an("wait_rel_d2", 4'b1011);
        check("rel_d2_seg_0", {9'b0, Seg4}, 16'h0040);

        // 3: non-BCD digit flags Invalid and shows a dash
        SCin = 16'h12A4;
        step(1);
        check("inv_lat1", {15'b0, Inv4}, 16'd0);
        step(1);
        check("inv_set", {15'b0, Inv4}, 16'd1);
        wait_an("wait_dash", 4'b1101);
        check("dash_seg", {9'b0, Seg4}, 16'h003F);
        SCin = 16'h1234;
        step(1);
        check("inv_hold1", {15'b0, Inv4}, 16'd1);
        step(1);
        check("inv_clr", {15'b0, Inv4}, 16'd0);

        // 4: reset mid-scan restarts at digit0 for a full period
        wait_an("wait_d2", 4'b1011);
        Reset = 1'b1;
        Hold  = 1'b1;
        step(1);
        check("mid_rst_an",  {12'b0, An4}, 16'h000F);
        check("mid_rst_seg", {9'b0, Seg4}, 16'h007F);
        check("mid_rst_dp",  {15'b0, DP4}, 16'd1);
        Reset = 1'b0;
        Hold  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("restart_an4", {12'b0, An4}, 16'b1110);
            check("div1_an_seq", {12'b0, An1}, {12'b0, an1_seq[k]});
        end
        step(1);
        check("restart_next_an4", {12'b0, An4}, 16'b1101);
        check("div1_an_wrap", {12'b0, An1}, {12'b0, an1_seq[4]});

        // 5: leading zeros of 0005
        SCin = 16'h0005;
        step(3);
        wait_an("wait_lz_d3", 4'b0111);
`ifdef LEADING_ZERO_BLANK_EN
        check("lz_d3_seg", {9'b0, Seg4}, 16'h007F);
`else
        check("lz_d3_seg", {9'b0, Seg4}, 16'h0040);
`endif
        wait_an("wait_lz_d1", 4'b1101);
        check("lz_d1_seg", {9'b0, Seg4}, 16'h0040);
        check("lz_d1_dp",  {15'b0, DP4}, 16'd0);
        wait_an("wait_lz_d0", 4'b1110);
        check("lz_d0_seg", {9'b0, Seg4}, 16'h0012);
        step(16);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
